// File: rtl/karatsuba_mult_seq.sv
// Sequential one-level Karatsuba multiplier: three sub-products time-share one
// (HALF+1)x(HALF+1) multiplier, then are recombined into the full product.
module karatsuba_mult_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned MW   = HALF + 1;
    localparam int unsigned PW   = 2 * HALF + 2;
    localparam int unsigned ZW   = 2 * HALF;
    localparam int unsigned OW   = 2 * WIDTH;

    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("karatsuba_mult_seq: WIDTH must be even and >= 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        MUL_HI,
        MUL_LO,
        MUL_MID,
        COMBINE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [ZW-1:0]   z2_q, z2_d;
    logic [ZW-1:0]   z0_q, z0_d;
    logic [PW-1:0]   zm_q, zm_d;
    logic [OW-1:0]   out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [HALF-1:0] xh_c, xl_c, yh_c, yl_c;
    logic [MW-1:0]   mul_a_c, mul_b_c;
    logic [PW-1:0]   mul_p_c;
    logic [PW-1:0]   z1_c;

    assign xh_c = x_q[WIDTH-1:HALF];
    assign xl_c = x_q[HALF-1:0];
    assign yh_c = y_q[WIDTH-1:HALF];
    assign yl_c = y_q[HALF-1:0];

    // Operand mux for the single shared multiplier, selected by state.
    always_comb begin
        mul_a_c = '0;
        mul_b_c = '0;
        case (state_q)
            MUL_HI: begin
                mul_a_c = MW'(xh_c);
                mul_b_c = MW'(yh_c);
            end
            MUL_LO: begin
                mul_a_c = MW'(xl_c);
                mul_b_c = MW'(yl_c);
            end
            MUL_MID: begin
                mul_a_c = MW'(xh_c) + MW'(xl_c);
                mul_b_c = MW'(yh_c) + MW'(yl_c);
            end
            default: ;
        endcase
    end

    assign mul_p_c = PW'(mul_a_c) * PW'(mul_b_c);

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z2_d        = z2_q;
        z0_d        = z0_q;
        zm_d        = zm_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        // Middle term; zm >= z2 + z0 always, so unsigned subtraction is exact.
        z1_c        = zm_q - PW'(z2_q) - PW'(z0_q);
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = x;
                    y_d     = y;
                    state_d = MUL_HI;
                end
            end
            MUL_HI: begin
                z2_d    = mul_p_c[ZW-1:0];
                state_d = MUL_LO;
            end
            MUL_LO: begin
                z0_d    = mul_p_c[ZW-1:0];
                state_d = MUL_MID;
            end
            MUL_MID: begin
                zm_d    = mul_p_c;
                state_d = COMBINE;
            end
            COMBINE: begin
                out_d       = (OW'(z2_q) << WIDTH) + (OW'(z1_c) << HALF) + OW'(z0_q);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z2_q        <= '0;
            z0_q        <= '0;
            zm_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z2_q        <= z2_d;
            z0_q        <= z0_d;
            zm_q        <= zm_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_karatsuba_mult_seq.sv
// Scoreboard bench: four lanes (WIDTH 4/8/16/32) share clk/rst; stimulus pushes
// expected products, a negedge monitor pops and checks them plus handshake rules.
module tb_karatsuba_mult_seq;

    localparam int unsigned NLANE  = 4;
    localparam int unsigned SOAK_N = 2000;
    localparam int          L8     = 1;
    localparam int          L16    = 2;

    typedef struct {
        logic [63:0] exp;
        logic [31:0] xv;
        logic [31:0] yv;
        int unsigned acc;
    } item_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid_a  [NLANE];
    logic             out_ready_a [NLANE];
    logic [31:0]      x_a         [NLANE];
    logic [31:0]      y_a         [NLANE];
    logic [NLANE-1:0] in_ready_a;
    logic [NLANE-1:0] out_valid_a;
    logic [63:0]      out_a       [NLANE];

    item_t       exp_q [NLANE][$];
    item_t       st_it;
    item_t       mon_it;
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    bit          done  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        localparam int unsigned W = 4 << g;
        logic [2*W-1:0] o_w;
        karatsuba_mult_seq #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .x         (x_a[g][W-1:0]),
            .y         (y_a[g][W-1:0]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out       (o_w)
        );
        assign out_a[g] = 64'(o_w);
    end

    function automatic logic [31:0] lane_mask(input int l);
        logic [31:0] one;
        one = 32'd1;
        return (l == 3) ? 32'hFFFF_FFFF : ((one << (4 << l)) - 32'd1);
    endfunction

    task automatic chk(input string nm, input int l, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s lane=%0d got=0x%0h want=0x%0h", nm, l, got, want);
        end
    endtask

    // Monitor: scoreboard pops, reset values, latency, hold and release rules.
    bit          prev_rst = 1'b0;
    bit          prev_v [NLANE];
    bit          prev_r [NLANE];
    logic [63:0] prev_o [NLANE];

    always @(negedge clk) begin
        if (done || cyc > 90000) begin
            if (!done) chk("watchdog", 0, 64'd1, 64'(done));
            for (int l = 0; l < NLANE; l++) chk("leftover", l, 64'(exp_q[l].size()), 64'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        for (int l = 0; l < NLANE; l++) begin
            if (prev_rst) begin
                chk("rst_valid", l, 64'(out_valid_a[l]), 64'd0);
                chk("rst_ready", l, 64'(in_ready_a[l]), 64'd1);
                chk("rst_out", l, out_a[l], 64'd0);
            end else begin
                if (out_valid_a[l] && !prev_v[l]) begin
                    if (exp_q[l].size() == 0) chk("spurious_valid", l, 64'(out_valid_a[l]), 64'd0);
                    else chk("latency", l, 64'(cyc - exp_q[l][0].acc), 64'd4);
                end
                if (prev_v[l] && !prev_r[l]) begin
                    chk("hold_valid", l, 64'(out_valid_a[l]), 64'd1);
                    chk("hold_out", l, out_a[l], prev_o[l]);
                end
                if (prev_v[l] && prev_r[l]) begin
                    chk("drop_valid", l, 64'(out_valid_a[l]), 64'd0);
                    chk("idle_ready", l, 64'(in_ready_a[l]), 64'd1);
                    chk("keep_out", l, out_a[l], prev_o[l]);
                end
                if (out_valid_a[l]) chk("busy_ready", l, 64'(in_ready_a[l]), 64'd0);
                if (out_valid_a[l] && out_ready_a[l]) begin
                    if (exp_q[l].size() == 0) begin
                        chk("unexpected_out", l, 64'(out_valid_a[l]), 64'd0);
                    end else begin
                        mon_it = exp_q[l].pop_front();
                        chk("data", l, out_a[l], mon_it.exp);
                        chk("model", l, out_a[l], 64'(mon_it.xv) * 64'(mon_it.yv));
                    end
                end
            end
            prev_v[l] = out_valid_a[l];
            prev_r[l] = out_ready_a[l];
            prev_o[l] = out_a[l];
        end
        prev_rst = rst;
    end

    // Offer one pair on lane l (waits for in_ready) and record its expected product.
    task automatic send(input int l, input logic [31:0] xv, input logic [31:0] yv, input logic [63:0] ev);
        int n;
        n = 0;
        while (!in_ready_a[l] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        x_a[l] = xv;
        y_a[l] = yv;
        in_valid_a[l] = 1'b1;
        st_it.exp = ev;
        st_it.xv  = xv;
        st_it.yv  = yv;
        st_it.acc = cyc + 1;
        exp_q[l].push_back(st_it);
        @(posedge clk); #1;
        in_valid_a[l] = 1'b0;
    endtask

    task automatic wait_drain(input int l);
        int n;
        n = 0;
        while (exp_q[l].size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
    endtask

    int unsigned acc_n [NLANE];
    bit          all_done;
    logic [31:0] sx, sy, msk;
    int          n_wait;

    // Stimulus: directed vectors, backpressure, reset mid-op, then random soak.
    initial begin
        for (int l = 0; l < NLANE; l++) begin
            in_valid_a[l]  = 1'b0;
            out_ready_a[l] = 1'b1;
            x_a[l]         = '0;
            y_a[l]         = '0;
            acc_n[l]       = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(L16, 32'h0000, 32'h0000, 64'h0000_0000);
        wait_drain(L16);
        send(L16, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001);
        send(L16, 32'h7901, 32'h8101, 64'h3CF9_FA01);
        wait_drain(L16);

        send(L8, 32'h79, 32'h81, 64'h3CF9);
        send(L8, 32'h02, 32'h51, 64'h00A2);
        send(L8, 32'h30, 32'h0B, 64'h0210);
        send(L8, 32'h08, 32'h02, 64'h0010);
        send(L8, 32'hFF, 32'hFF, 64'hFE01);
        wait_drain(L8);

        // Backpressure: stall DONE for 7 cycles while fresh data is offered.
        out_ready_a[L16] = 1'b0;
        send(L16, 32'h1234, 32'h5678, 64'h0626_0060);
        n_wait = 0;
        while (!out_valid_a[L16] && n_wait < 50) begin
            @(posedge clk); #1;
            n_wait++;
        end
        repeat (7) begin
            x_a[L16] = $urandom() & 32'hFFFF;
            y_a[L16] = $urandom() & 32'hFFFF;
            in_valid_a[L16] = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_a[L16]  = 1'b0;
        out_ready_a[L16] = 1'b1;
        send(L16, 32'h0002, 32'h0003, 64'h0000_0006);
        wait_drain(L16);

        // Reset while in MUL_MID: the abandoned pair must never emerge.
        send(L16, 32'hABCD, 32'h1111, 64'h0B74_059D);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int l = 0; l < NLANE; l++) exp_q[l].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        send(L16, 32'h0003, 32'h0005, 64'h0000_000F);
        wait_drain(L16);

        // Random soak on all widths with random in_valid/out_ready gaps.
        all_done = 1'b0;
        while (!all_done) begin
            all_done = 1'b1;
            for (int l = 0; l < NLANE; l++) begin
                if (acc_n[l] < SOAK_N) begin
                    all_done = 1'b0;
                    msk = lane_mask(l);
                    case ($urandom_range(0, 7))
                        0: sx = '1;
                        1: sx = '0;
                        default: sx = $urandom();
                    endcase
                    case ($urandom_range(0, 7))
                        0: sy = '1;
                        1: sy = '0;
                        default: sy = $urandom();
                    endcase
                    sx = sx & msk;
                    sy = sy & msk;
                    x_a[l] = sx;
                    y_a[l] = sy;
                    in_valid_a[l]  = ($urandom_range(0, 3) != 0);
                    out_ready_a[l] = ($urandom_range(0, 3) != 0);
                    if (in_valid_a[l] && in_ready_a[l]) begin
                        st_it.exp = 64'(sx) * 64'(sy);
                        st_it.xv  = sx;
                        st_it.yv  = sy;
                        st_it.acc = cyc + 1;
                        exp_q[l].push_back(st_it);
                        acc_n[l]++;
                    end
                end else begin
                    in_valid_a[l]  = 1'b0;
                    out_ready_a[l] = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        for (int l = 0; l < NLANE; l++) wait_drain(l);
        done = 1'b1;
    end

endmodule
